// File: rtl/vga_layer_mixer.sv
// N-layer priority compositor for the VGA pipeline: picks the highest enabled, non-keyed
// layer pixel and re-emits it with the timing strobes after a fixed LATENCY-cycle delay.
module vga_layer_mixer #(
    parameter int                  N_LAYERS = 4,
    parameter int                  LATENCY  = 2,
    parameter int                  RGB_W    = 12,
    parameter int                  CNT_W    = 11,
    parameter int                  KEY_EN   = 1,
    parameter logic [RGB_W-1:0]    KEY_RGB  = 12'hF0F,
    parameter logic [N_LAYERS-1:0] EN_RESET = {N_LAYERS{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CNT_W-1:0]          in_hcount,
    input  logic [CNT_W-1:0]          in_vcount,
    input  logic                      in_hsync,
    input  logic                      in_vsync,
    input  logic                      in_hblnk,
    input  logic                      in_vblnk,
    input  logic [RGB_W-1:0]          in_rgb,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]       layer_valid,
    input  logic [N_LAYERS-1:0]       layer_en_req,
    input  logic                      en_update,
    output logic [CNT_W-1:0]          out_hcount,
    output logic [CNT_W-1:0]          out_vcount,
    output logic                      out_hsync,
    output logic                      out_vsync,
    output logic                      out_hblnk,
    output logic                      out_vblnk,
    output logic [RGB_W-1:0]          out_rgb,
    output logic [N_LAYERS-1:0]       en_active,
    output logic                      update_pending,
    output logic [15:0]               frame_cnt
);

    localparam int PW = 2*CNT_W + 4 + RGB_W;

    logic [PW-1:0]       r_pipe [0:LATENCY-1];
    logic [N_LAYERS-1:0] r_en_active;
    logic [N_LAYERS-1:0] r_en_pending;
    logic                r_update_pending;
    logic [15:0]         r_frame_cnt;
    logic                r_vsync_prev;

    logic                w_frame_edge;
    logic [RGB_W-1:0]    w_sel_rgb;
    logic [PW-1:0]       w_stage_in;

    assign w_frame_edge = in_vsync & ~r_vsync_prev;

    // Ascending scan so the highest-index visible layer overrides lower ones.
    always_comb begin
        w_sel_rgb = in_rgb;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (layer_valid[i] && r_en_active[i] &&
                !((KEY_EN != 0) && (layer_rgb[i*RGB_W +: RGB_W] == KEY_RGB))) begin
                w_sel_rgb = layer_rgb[i*RGB_W +: RGB_W];
            end
        end
        if (in_hblnk || in_vblnk) begin
            w_sel_rgb = '0;
        end
    end

    assign w_stage_in = {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, w_sel_rgb};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int k = 1; k < LATENCY; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    // A strobe coinciding with the frame edge bypasses the pending register entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_active      <= EN_RESET;
            r_en_pending     <= '0;
            r_update_pending <= 1'b0;
            r_frame_cnt      <= '0;
            r_vsync_prev     <= 1'b0;
        end else begin
            r_vsync_prev <= in_vsync;
            if (w_frame_edge) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (en_update && w_frame_edge) begin
                r_en_active      <= layer_en_req;
                r_update_pending <= 1'b0;
            end else if (en_update) begin
                r_en_pending     <= layer_en_req;
                r_update_pending <= 1'b1;
            end else if (w_frame_edge && r_update_pending) begin
                r_en_active      <= r_en_pending;
                r_update_pending <= 1'b0;
            end
        end
    end

    assign {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb} = r_pipe[LATENCY-1];
    assign en_active      = r_en_active;
    assign update_pending = r_update_pending;
    assign frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed vector table plus corner sequences and a random scoreboard for vga_layer_mixer.
module tb_vga_layer_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] in_hcount, in_vcount;
    logic        in_hsync, in_vsync, in_hblnk, in_vblnk;
    logic [11:0] in_rgb;
    logic [47:0] layer_rgb;
    logic [3:0]  layer_valid, layer_en_req;
    logic        en_update;

    logic [10:0] out_hcount, out_vcount;
    logic        out_hsync, out_vsync, out_hblnk, out_vblnk;
    logic [11:0] out_rgb;
    logic [3:0]  en_active;
    logic        update_pending;
    logic [15:0] frame_cnt;

    logic [10:0] nk_hcount, nk_vcount;
    logic        nk_hsync, nk_vsync, nk_hblnk, nk_vblnk;
    logic [11:0] nk_rgb;
    logic [3:0]  nk_en_active;
    logic        nk_pending;
    logic [15:0] nk_frame_cnt;

    logic [95:0] l8_rgb;
    logic [7:0]  l8_valid;
    logic [10:0] w8_hcount, w8_vcount;
    logic        w8_hsync, w8_vsync, w8_hblnk, w8_vblnk;
    logic [11:0] w8_rgb;
    logic [7:0]  w8_en_active;
    logic        w8_pending;
    logic [15:0] w8_frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_layer_mixer dut (
        .clk(clk), .rst(rst), .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
        .in_rgb(in_rgb), .layer_rgb(layer_rgb), .layer_valid(layer_valid),
        .layer_en_req(layer_en_req), .en_update(en_update),
        .out_hcount(out_hcount), .out_vcount(out_vcount), .out_hsync(out_hsync),
        .out_vsync(out_vsync), .out_hblnk(out_hblnk), .out_vblnk(out_vblnk),
        .out_rgb(out_rgb), .en_active(en_active), .update_pending(update_pending),
        .frame_cnt(frame_cnt)
    );

    vga_layer_mixer #(.KEY_EN(0)) dut_nokey (
        .clk(clk), .rst(rst), .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
        .in_rgb(in_rgb), .layer_rgb(layer_rgb), .layer_valid(layer_valid),
        .layer_en_req(layer_en_req), .en_update(en_update),
        .out_hcount(nk_hcount), .out_vcount(nk_vcount), .out_hsync(nk_hsync),
        .out_vsync(nk_vsync), .out_hblnk(nk_hblnk), .out_vblnk(nk_vblnk),
        .out_rgb(nk_rgb), .en_active(nk_en_active), .update_pending(nk_pending),
        .frame_cnt(nk_frame_cnt)
    );

    vga_layer_mixer #(.N_LAYERS(8), .LATENCY(8)) dut8 (
        .clk(clk), .rst(rst), .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
        .in_rgb(in_rgb), .layer_rgb(l8_rgb), .layer_valid(l8_valid),
        .layer_en_req(8'h00), .en_update(1'b0),
        .out_hcount(w8_hcount), .out_vcount(w8_vcount), .out_hsync(w8_hsync),
        .out_vsync(w8_vsync), .out_hblnk(w8_hblnk), .out_vblnk(w8_vblnk),
        .out_rgb(w8_rgb), .en_active(w8_en_active), .update_pending(w8_pending),
        .frame_cnt(w8_frame_cnt)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [47:0] lrgb;
        logic [11:0] bg;
        logic        hb;
        logic        vb;
        logic [10:0] hc;
        logic [11:0] exp_key;
        logic [11:0] exp_nokey;
    } vec_t;

    vec_t tbl [8];
    logic [37:0] exp_q [$];
    logic [37:0] exp8_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: search from the top-priority layer down, first visible one wins.
    function automatic logic [11:0] model_rgb(input logic [95:0] lr, input logic [7:0] v,
                                              input logic [7:0] en, input int n,
                                              input logic [11:0] bg, input logic blank,
                                              input logic key);
        logic [11:0] p;
        if (blank) return 12'h000;
        for (int i = n - 1; i >= 0; i--) begin
            p = lr[i*12 +: 12];
            if (v[i] && en[i] && !(key && p == 12'hF0F)) return p;
        end
        return bg;
    endfunction

    initial begin
        rst = 1'b1; in_hcount = '0; in_vcount = '0; in_hsync = 0; in_vsync = 0;
        in_hblnk = 0; in_vblnk = 0; in_rgb = '0; layer_rgb = '0; layer_valid = '0;
        layer_en_req = '0; en_update = 0; l8_rgb = '0; l8_valid = '0;

        tbl[0] = '{4'b0000, 48'h0, 12'h123, 0, 0, 11'd10, 12'h123, 12'h123};
        tbl[1] = '{4'b0000, 48'h0, 12'h123, 1, 0, 11'd11, 12'h000, 12'h000};
        tbl[2] = '{4'b0101, {12'h000, 12'hF00, 12'h000, 12'h00F}, 12'h123, 0, 0, 11'd12, 12'hF00, 12'hF00};
        tbl[3] = '{4'b0101, {12'h000, 12'hF0F, 12'h000, 12'h00F}, 12'h123, 0, 0, 11'd13, 12'h00F, 12'hF0F};
        tbl[4] = '{4'b1111, {12'h0AB, 12'hF00, 12'h0F0, 12'h00F}, 12'h123, 0, 0, 11'd14, 12'h0AB, 12'h0AB};
        tbl[5] = '{4'b1000, {12'hF0F, 12'hF00, 12'h0F0, 12'h00F}, 12'h456, 0, 0, 11'd15, 12'h456, 12'hF0F};
        tbl[6] = '{4'b0011, {12'h000, 12'h000, 12'h0F0, 12'h00F}, 12'h456, 0, 1, 11'd16, 12'h000, 12'h000};
        tbl[7] = '{4'b0010, {12'h000, 12'h000, 12'hF0F, 12'h00F}, 12'h789, 0, 0, 11'd17, 12'h789, 12'hF0F};

        repeat (2) tick();
        check("reset_out_rgb", out_rgb, 12'h000);
        check("reset_out_hcount", out_hcount, 11'd0);
        check("reset_en_active", en_active, 4'hF);
        check("reset_pending", update_pending, 1'b0);
        check("reset_frame_cnt", frame_cnt, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            layer_valid = tbl[i].valid; layer_rgb = tbl[i].lrgb; in_rgb = tbl[i].bg;
            in_hblnk = tbl[i].hb; in_vblnk = tbl[i].vb; in_hcount = tbl[i].hc;
            repeat (2) tick();
            check($sformatf("vec%0d_rgb", i), out_rgb, tbl[i].exp_key);
            check($sformatf("vec%0d_nokey_rgb", i), nk_rgb, tbl[i].exp_nokey);
            check($sformatf("vec%0d_hcount", i), out_hcount, tbl[i].hc);
        end

        // Deferred enable: captured mid-frame, applied on the vsync rising edge.
        layer_valid = 4'b1111; layer_rgb = {12'h0AB, 12'hF00, 12'h0F0, 12'h00F};
        in_rgb = 12'h000; in_hblnk = 0; in_vblnk = 0;
        en_update = 1; layer_en_req = 4'b0001;
        tick();
        en_update = 0;
        check("defer_en_unchanged", en_active, 4'hF);
        check("defer_pending_set", update_pending, 1'b1);
        repeat (2) tick();
        check("defer_old_mask_pixel", out_rgb, 12'h0AB);
        in_vsync = 1;
        tick();
        check("defer_en_applied", en_active, 4'b0001);
        check("defer_pending_clear", update_pending, 1'b0);
        check("defer_frame_cnt", frame_cnt, 16'd1);
        tick();
        check("defer_edge_pixel_old_mask", out_rgb, 12'h0AB);
        tick();
        check("defer_new_mask_pixel", out_rgb, 12'h00F);

        // Strobe coincident with the frame edge.
        in_vsync = 0;
        tick();
        in_vsync = 1; en_update = 1; layer_en_req = 4'b1000;
        tick();
        en_update = 0; in_vsync = 0;
        check("simul_en_active", en_active, 4'b1000);
        check("simul_pending", update_pending, 1'b0);
        check("simul_frame_cnt", frame_cnt, 16'd2);

        // Last write wins.
        tick();
        en_update = 1; layer_en_req = 4'b0011;
        tick();
        layer_en_req = 4'b0110;
        tick();
        en_update = 0;
        check("lastwin_pending", update_pending, 1'b1);
        check("lastwin_en_hold", en_active, 4'b1000);
        in_vsync = 1;
        tick();
        check("lastwin_en_active", en_active, 4'b0110);
        check("lastwin_frame_cnt", frame_cnt, 16'd3);
        repeat (2) tick();
        check("lastwin_pixel", out_rgb, 12'hF00);

        // Mid-frame reset with vsync still high: pipeline flushes, vsync counts as an edge.
        layer_valid = 4'b0000; in_rgb = 12'h123;
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        check("midrst_out0", out_rgb, 12'h000);
        check("midrst_en_active", en_active, 4'hF);
        check("midrst_frame_cnt", frame_cnt, 16'd0);
        check("midrst_pending", update_pending, 1'b0);
        tick();
        check("midrst_out1", out_rgb, 12'h000);
        check("midrst_vsync_edge", frame_cnt, 16'd1);
        tick();
        check("midrst_out2", out_rgb, 12'h123);

        // Frame counter wrap.
        in_vsync = 0;
        tick();
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        check("wrap_preload", frame_cnt, 16'hFFFF);
        in_vsync = 1;
        tick();
        check("wrap_to_zero", frame_cnt, 16'h0000);
        in_vsync = 0;

        // Random stream against the model, default and 8-layer/8-deep configurations.
        rst = 1;
        tick();
        rst = 0;
        exp_q.delete(); exp8_q.delete();
        for (int c = 0; c < 200; c++) begin
            in_hcount = 11'($urandom); in_vcount = 11'($urandom);
            in_hsync = 1'($urandom); in_vsync = 0;
            in_hblnk = ($urandom_range(0, 7) == 0); in_vblnk = ($urandom_range(0, 7) == 0);
            in_rgb = 12'($urandom);
            layer_valid = 4'($urandom); l8_valid = 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                l8_rgb[i*12 +: 12] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
            end
            for (int i = 0; i < 4; i++) begin
                layer_rgb[i*12 +: 12] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
            end
            exp_q.push_back({in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk,
                model_rgb({48'h0, layer_rgb}, {4'h0, layer_valid}, 8'h0F, 4, in_rgb,
                          in_hblnk | in_vblnk, 1'b1)});
            exp8_q.push_back({in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk,
                model_rgb(l8_rgb, l8_valid, 8'hFF, 8, in_rgb, in_hblnk | in_vblnk, 1'b1)});
            tick();
            if (exp_q.size() == 2) begin
                check($sformatf("rand_c%0d", c),
                      {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb},
                      exp_q.pop_front());
            end
            if (exp8_q.size() == 8) begin
                check($sformatf("rand8_c%0d", c),
                      {w8_hcount, w8_vcount, w8_hsync, w8_vsync, w8_hblnk, w8_vblnk, w8_rgb},
                      exp8_q.pop_front());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
